mmcu_sched: RTL and testbench

Sequencing controller in front of the 64-lane metric computation array. It accepts received symbols (u, h) over a valid/ready handshake and registers them onto the array's shared operand bus. It selects the constellation LUT mode and drains and re-settles the pipeline on every mode change. It also tags metric validity and frame boundaries, and gates issue with a credit counter, because the metric array has no stall path.

---
 rtl/mmcu_sched.sv | 198 +++++++++++++++++++
 tb/tb_mmcu_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcu_sched.sv
// rtl/mmcu_sched.sv - issue sequencer for the 64-lane metric computation array
//
// Accepts received symbols (u, h) over a valid/ready handshake and registers
// them onto the array's shared operand bus. Switching constellation mode
// first drains the array pipeline, then waits for the LUT ROM to settle.
// Issue is gated by downstream buffer credits because the array cannot stall.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid / in_ready           symbol handshake
//   in_u_re, in_u_im, in_h        received symbol and channel gain (Q8.10)
//   in_mode                       constellation mode (0..4 legal, 5..7 illegal)
//   in_last                       last symbol of frame
//   u_re_o, u_im_o, h_o           registered operand bus to the array
//   lut_mode_o, active_num_o      LUT ROM mode select and its point count
//   metric_valid_o, metric_last_o array output qualifiers
//   credit_ret_i                  one downstream buffer slot freed
//   err_mode_o                    sticky illegal-mode flag
//   busy_o                        not in RUN, or issues still in flight

module mmcu_sched #(
    parameter int WORDLENGTH = 18,
    parameter int MODE_W     = 3,
    parameter int PIPE_LAT   = 1,
    parameter int LUT_LAT    = 2,
    parameter int CREDITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORDLENGTH-1:0] in_u_re,
    input  logic [WORDLENGTH-1:0] in_u_im,
    input  logic [WORDLENGTH-1:0] in_h,
    input  logic [MODE_W-1:0]     in_mode,
    input  logic                  in_last,
    output logic [WORDLENGTH-1:0] u_re_o,
    output logic [WORDLENGTH-1:0] u_im_o,
    output logic [WORDLENGTH-1:0] h_o,
    output logic [MODE_W-1:0]     lut_mode_o,
    output logic [6:0]            active_num_o,
    output logic                  metric_valid_o,
    output logic                  metric_last_o,
    input  logic                  credit_ret_i,
    output logic                  err_mode_o,
    output logic                  busy_o
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int SW = (LUT_LAT < 1) ? 1 : $clog2(LUT_LAT + 1);
    localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(4);

    typedef enum logic [1:0] {SETTLE, RUN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [SW-1:0]       settle_cnt, settle_cnt_nxt;
    logic [MODE_W-1:0]   pend_mode, pend_mode_nxt;
    logic [MODE_W-1:0]   lut_mode_nxt;
    logic [CW-1:0]       credits;
    logic [PIPE_LAT-1:0] iss_v, iss_l;

    logic mode_illegal, mode_match, switch_req, pipe_empty;
    logic accept, acc_legal, acc_bad;

    assign mode_illegal = (in_mode > MODE_MAX);
    assign mode_match   = (in_mode == lut_mode_o);
    assign pipe_empty   = (iss_v == '0);

    // Illegal modes are swallowed in RUN regardless of the LUT mode, so they
    // never trigger a drain.
    assign in_ready  = (state == RUN) && (credits != '0) &&
                       (mode_match || mode_illegal || !in_valid);
    assign accept    = in_valid && in_ready;
    assign acc_legal = accept && !mode_illegal;
    assign acc_bad   = accept && mode_illegal;
    assign switch_req = (state == RUN) && in_valid && !mode_illegal && !mode_match;

    assign busy_o = (state != RUN) || !pipe_empty;

    always_comb begin
        active_num_o = 7'd4;
        case (lut_mode_o)
            3'd0:    active_num_o = 7'd4;
            3'd1:    active_num_o = 7'd8;
            3'd2:    active_num_o = 7'd16;
            3'd3:    active_num_o = 7'd32;
            3'd4:    active_num_o = 7'd64;
            default: active_num_o = 7'd4;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        pend_mode_nxt  = pend_mode;
        lut_mode_nxt   = lut_mode_o;
        case (state)
            SETTLE: begin
                // The edge that takes the counter to zero also enters RUN, so
                // in_ready rises LUT_LAT edges after the LUT select changed.
                if (settle_cnt <= SW'(1)) begin
                    settle_cnt_nxt = '0;
                    state_nxt      = RUN;
                end else begin
                    settle_cnt_nxt = settle_cnt - SW'(1);
                end
            end
            RUN: begin
                if (switch_req) begin
                    pend_mode_nxt = in_mode;
                    state_nxt     = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    lut_mode_nxt   = pend_mode;
                    settle_cnt_nxt = SW'(LUT_LAT);
                    state_nxt      = SETTLE;
                end
            end
            default: state_nxt = SETTLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SETTLE;
            settle_cnt <= SW'(LUT_LAT);
            pend_mode  <= '0;
            lut_mode_o <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            pend_mode  <= pend_mode_nxt;
            lut_mode_o <= lut_mode_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= CW'(CREDITS);
        end else begin
            case ({acc_legal, credit_ret_i})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   if (credits != CW'(CREDITS)) credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Issue tracker mirrors the array pipeline depth; metric qualifiers are
    // registered once more to line up with the array's output register.
    if (PIPE_LAT > 1) begin : g_pipe_deep
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                iss_v <= '0;
                iss_l <= '0;
            end else begin
                iss_v <= {iss_v[PIPE_LAT-2:0], acc_legal};
                iss_l <= {iss_l[PIPE_LAT-2:0], in_last};
            end
        end
    end else begin : g_pipe_one
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                iss_v <= '0;
                iss_l <= '0;
            end else begin
                iss_v <= acc_legal;
                iss_l <= in_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            metric_valid_o <= 1'b0;
            metric_last_o  <= 1'b0;
            u_re_o         <= '0;
            u_im_o         <= '0;
            h_o            <= '0;
            err_mode_o     <= 1'b0;
        end else begin
            metric_valid_o <= iss_v[PIPE_LAT-1];
            metric_last_o  <= iss_v[PIPE_LAT-1] & iss_l[PIPE_LAT-1];
            // Operand bus holds between accepts; no bubble zeroing.
            if (acc_legal) begin
                u_re_o <= in_u_re;
                u_im_o <= in_u_im;
                h_o    <= in_h;
            end
            if (acc_bad) begin
                err_mode_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mmcu_sched.sv
// tb/tb_mmcu_sched.sv - scoreboard testbench for mmcu_sched
module tb_mmcu_sched;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_u_re, in_u_im, in_h;
    logic [2:0]  in_mode;
    logic        in_last;
    logic [17:0] u_re_o, u_im_o, h_o;
    logic [2:0]  lut_mode_o;
    logic [6:0]  active_num_o;
    logic        metric_valid_o, metric_last_o;
    logic        credit_ret_i;
    logic        err_mode_o, busy_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_acc = 0;
    int mcount = 0;
    int ml_cnt = 0;
    logic exp_q[$];
    int   mv_cyc[$];

    mmcu_sched dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_u_re(in_u_re), .in_u_im(in_u_im), .in_h(in_h),
        .in_mode(in_mode), .in_last(in_last),
        .u_re_o(u_re_o), .u_im_o(u_im_o), .h_o(h_o),
        .lut_mode_o(lut_mode_o), .active_num_o(active_num_o),
        .metric_valid_o(metric_valid_o), .metric_last_o(metric_last_o),
        .credit_ret_i(credit_ret_i),
        .err_mode_o(err_mode_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every metric the array presents must match the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        if (!rst && metric_valid_o) begin
            logic e;
            mcount++;
            mv_cyc.push_back(cyc);
            if (metric_last_o) ml_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL metric_unexpected: got metric at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                if (metric_last_o !== e) begin
                    fails++;
                    $display("FAIL metric_last: got %0b expected %0b", metric_last_o, e);
                end
            end
        end
    end

    task automatic send(input logic [2:0] m, input logic [17:0] u, input logic l,
                        input bit iss, input int budget, output bit ok);
        logic [17:0] ui, hh;
        ui = ~u;
        hh = u + 18'd1;
        in_mode = m; in_u_re = u; in_u_im = ui; in_h = hh; in_last = l;
        in_valid = 1'b1;
        ok = 1'b0;
        #1;
        for (int i = 0; i < budget; i++) begin
            if (in_ready) begin
                if (iss) exp_q.push_back(l);
                @(posedge clk);
                #1;
                ok = 1'b1;
                last_acc = cyc;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (ok && iss) begin
            check("bus_u_re", u_re_o, u);
            check("bus_u_im", u_im_o, ui);
            check("bus_h", h_o, hh);
        end
    endtask

    task automatic ret(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            credit_ret_i = 1'b1;
            @(negedge clk);
            credit_ret_i = 1'b0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_u_re"}, u_re_o, 0);
        check({tag, "_u_im"}, u_im_o, 0);
        check({tag, "_h"}, h_o, 0);
        check({tag, "_lut_mode"}, lut_mode_o, 0);
        check({tag, "_active_num"}, active_num_o, 4);
        check({tag, "_metric_valid"}, metric_valid_o, 0);
        check({tag, "_metric_last"}, metric_last_o, 0);
        check({tag, "_err_mode"}, err_mode_o, 0);
        check({tag, "_busy"}, busy_o, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int rel, acc0, k, n_acc;
        logic [17:0] xv;

        rst = 1'b1; in_valid = 1'b0; in_u_re = '0; in_u_im = '0; in_h = '0;
        in_mode = '0; in_last = 1'b0; credit_ret_i = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check_reset_vals("rst0");

        // Reset release, 4 back-to-back mode-0 symbols
        in_valid = 1'b1; in_mode = 3'd0;
        rst = 1'b0;
        rel = cyc;
        @(negedge clk);
        check("settle1_ready", in_ready, 0);
        @(negedge clk);
        check("settle2_ready", in_ready, 1);
        send(3'd0, 18'h00101, 1'b0, 1'b1, 4, ok);
        check("t1_acc0", ok, 1);
        acc0 = last_acc;
        check("t1_first_accept_edge", acc0 - rel, 3);
        check("t1_mv_latency", metric_valid_o, 0);
        for (int i = 1; i < 4; i++) begin
            send(3'd0, 18'h00101 + 18'(i), 1'b0, 1'b1, 1, ok);
            check("t1_acc_b2b", ok, 1);
        end
        repeat (3) @(negedge clk);
        check("t1_metrics", mv_cyc.size(), 4);
        if (mv_cyc.size() == 4) begin
            check("t1_mv_first", mv_cyc[0], acc0 + 1);
            check("t1_mv_consec", mv_cyc[3], acc0 + 4);
        end
        check("t1_active_num", active_num_o, 4);

        // Mode 2 stream, then a mode-4 symbol
        send(3'd2, 18'h00201, 1'b0, 1'b1, 15, ok);
        check("t2_acc_m2", ok, 1);
        send(3'd2, 18'h00202, 1'b0, 1'b1, 3, ok);
        check("t2_acc_m2b", ok, 1);
        send(3'd2, 18'h00203, 1'b0, 1'b1, 3, ok);
        check("t2_acc_m2c", ok, 1);
        check("t2_lut2", lut_mode_o, 2);
        k = last_acc;
        send(3'd4, 18'h00401, 1'b0, 1'b1, 15, ok);
        check("t2_acc_m4", ok, 1);
        check("t2_switch_penalty", last_acc - k, 5);
        check("t2_lut4", lut_mode_o, 4);
        check("t2_active_num", active_num_o, 64);

        // Credits exhausted: refill with one extra (saturating) return
        ret(9);
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            send(3'd4, 18'h00500 + 18'(i), 1'b0, 1'b1, 3, ok);
            n_acc += int'(ok);
        end
        check("t3_accepted", n_acc, 8);
        in_valid = 1'b1;
        #1;
        check("t3_ready_low", in_ready, 0);
        in_valid = 1'b0;
        ret(1);
        send(3'd4, 18'h00510, 1'b0, 1'b1, 3, ok);
        check("t3_one_more", ok, 1);
        send(3'd4, 18'h00511, 1'b0, 1'b1, 3, ok);
        check("t3_then_none", ok, 0);
        ret(1);
        credit_ret_i = 1'b1;
        send(3'd4, 18'h00512, 1'b0, 1'b1, 3, ok);
        credit_ret_i = 1'b0;
        check("t3_acc_with_ret", ok, 1);
        send(3'd4, 18'h00513, 1'b0, 1'b1, 3, ok);
        check("t3_count_unchanged", ok, 1);
        send(3'd4, 18'h00514, 1'b0, 1'b1, 3, ok);
        check("t3_now_empty", ok, 0);

        // Illegal mode mid-stream
        ret(8);
        xv = 18'h00601;
        send(3'd2, xv, 1'b0, 1'b1, 15, ok);
        check("t4_acc_m2", ok, 1);
        send(3'd6, 18'h3ffff, 1'b0, 1'b0, 3, ok);
        check("t4_illegal_consumed", ok, 1);
        check("t4_err", err_mode_o, 1);
        check("t4_bus_held", u_re_o, xv);
        k = last_acc;
        send(3'd2, 18'h00602, 1'b0, 1'b1, 3, ok);
        check("t4_next_m2", ok, 1);
        check("t4_no_stall", last_acc - k, 1);

        // Frame of 5 with in_last on the 5th
        for (int i = 0; i < 5; i++) begin
            send(3'd2, 18'h00700 + 18'(i), (i == 4), 1'b1, 3, ok);
            check("t5_acc", ok, 1);
        end
        repeat (4) @(negedge clk);
        check("t5_last_count", ml_cnt, 1);
        check("t5_err_sticky", err_mode_o, 1);

        // Reset with a symbol in flight
        send(3'd2, 18'h00801, 1'b0, 1'b0, 3, ok);
        check("t6_acc_inflight", ok, 1);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_async");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_acc = 0;
        send(3'd0, 18'h00900, 1'b0, 1'b1, 6, ok);
        n_acc += int'(ok);
        for (int i = 1; i < 10; i++) begin
            send(3'd0, 18'h00900 + 18'(i), 1'b0, 1'b1, 3, ok);
            n_acc += int'(ok);
        end
        check("t6_credits_restored", n_acc, 8);
        repeat (4) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_metric_count", mcount, 34);
        check("final_last_count", ml_cnt, 1);
        check("final_busy", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
